as_id_ex_stage: RTL and testbench
=================================

# as_id_ex_stage

ID/EX pipeline stage of the RV64I pipelined core: registers decoded operands, immediates, register addresses and control bits from ID and presents them to EX, the forwarding-detect logic and the EX forwarding muxes. Detects load-use hazards, inserts a one-cycle bubble, and squashes the ID instruction on a taken branch/jump resolved in EX. Counts stall cycles for performance monitoring.

## Interface
- XLEN, 64, datapath width
- CNT_W, 32, stall counter width
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous active-low reset
- hold_i  in  1  global freeze (data-memory wait); highest priority
- flush_i  in  1  taken branch/jump resolved in EX; squash ID instruction
- id_valid_i  in  1  ID holds a real instruction
- id_pc_i  in  XLEN  PC of ID instruction
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register-file read data
- id_imm_i  in  XLEN  sign-extended immediate
- id_rs1_i, id_rs2_i, id_rd_i  in  5  register addresses
- id_rs1_used_i, id_rs2_used_i  in  1  instruction actually reads rs1/rs2
- id_funct3_i  in  3  funct3
- id_ctrl_i  in  ctrl_t  decoded control (reg_wr, mem_rd, mem_wr, mem_to_reg, alu_src, alu_op, branch, jump)
- id_ex_valid_o  out  1  registered valid
- id_ex_pc_o, id_ex_rs1_data_o, id_ex_rs2_data_o, id_ex_imm_o  out  XLEN  registered fields
- id_ex_rs1_o, id_ex_rs2_o, id_ex_rd_o  out  5  registered addresses (rs1/rs2 feed forwarding detect)
- id_ex_funct3_o  out  3  registered funct3
- id_ex_ctrl_o  out  ctrl_t  registered control
- stall_o  out  1  hold PC and IF/ID this cycle
- stall_cnt_o  out  CNT_W  saturating stall-cycle count

## Operation
- Load-use (combinational): luh = id_ex_valid_o & id_ex_ctrl_o.mem_rd & (id_ex_rd_o != 0) & id_valid_i & ((id_rs1_used_i & id_rs1_i == id_ex_rd_o) | (id_rs2_used_i & id_rs2_i == id_ex_rd_o)).
- stall_o = luh & ~flush_i & ~hold_i.
- Register update at clock edge, priority order:
  - hold_i=1: all registers keep value; counter keeps value.
  - flush_i=1: load bubble.
  - luh=1: load bubble; counter increments.
  - else: load ID fields; valid <= id_valid_i; if id_valid_i=0, ctrl loaded as CTRL_NOP and rd as 0.
- Bubble: valid=0, ctrl=CTRL_NOP, all address, data, pc, imm and funct3 fields = 0 (rd=0 guarantees forwarding never matches).
- Counter: +1 per cycle with stall_o=1; saturates at all-ones, no wrap.
- After a load-use bubble the dependent instruction enters EX with the load in MEM/WB; forwarding resolves it via the MEM/WB path. No second stall cycle.

## Timing
- Reset (async assert, sync release at next edge): all outputs 0, ctrl=CTRL_NOP, stall_o=0, stall_cnt_o=0.
- Latency: one cycle ID to EX.
- stall_o is combinational, same cycle as luh; exactly one stall cycle per load-use pair.
- Simultaneous flush_i and luh: flush wins; stall_o=0; counter unchanged.
- hold_i during luh: stall_o=0 (pipeline frozen anyway); luh re-evaluated on release.
- rd=x0 load followed by an x0 reader: no stall.
- Reset asserted mid-stall: stall_o drops to 0 immediately, because valid clears asynchronously.

## Structure
- as_pack: XLEN, ctrl_t packed struct, CTRL_NOP constant (all fields 0).
- One sub-module: as_load_use_detect (combinational luh).
- Register block and counter live in as_id_ex_stage.

## Test plan
- ld x5 in ID/EX, add x6,x5,x7 in ID with rs1_used=1 -> stall_o=1 for one cycle; next edge id_ex_valid_o=0 and id_ex_rd_o=0; following edge add latched with id_ex_rs1_o=5; stall_cnt_o=1.
- ld x5 in EX, sw with rs2=5 and rs1_used=0 -> stall; same with rs2_used=0 and only rs1 matching via an unused field -> no stall.
- luh and flush_i in the same cycle -> stall_o=0; next cycle bubble; stall_cnt_o unchanged.
- hold_i=1 for 3 cycles with a valid add in ID/EX -> all outputs frozen; ID changes ignored; counter frozen.
- Preload counter near saturation (CNT_W=4 build), 20 stall cycles -> stall_cnt_o=15 and holds.
- Assert rst_ni=0 mid-stream -> all outputs 0 asynchronously and stall_o=0; first edge after release loads the ID instruction.

Source files
------------

// File: rtl/as_pack.sv
// Shared types and constants for the ID/EX stage of the RV64I pipeline.
// ctrl_t carries the decoded control bits that travel with an instruction into EX.
package as_pack;

  localparam int XLEN = 64;

  typedef struct packed {
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/as_load_use_detect.sv
// Combinational load-use hazard detect: a load in EX whose destination is
// read by the valid instruction currently in ID.
module as_load_use_detect (
  input  logic       ex_valid_i,
  input  logic       ex_mem_rd_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  output logic       luh_o
);

  logic rs1_hit;
  logic rs2_hit;

  // A load to x0 never produces a value worth waiting for.
  assign rs1_hit = id_rs1_used_i & (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_rs2_used_i & (id_rs2_i == ex_rd_i);
  assign luh_o   = ex_valid_i & ex_mem_rd_i & (ex_rd_i != 5'd0) & id_valid_i
                 & (rs1_hit | rs2_hit);

endmodule

// File: rtl/as_id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch squash,
// global hold and a saturating stall-cycle counter.
module as_id_ex_stage
  import as_pack::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [2:0]       id_funct3_i,
  input  ctrl_t            id_ctrl_i,
  output logic             id_ex_valid_o,
  output logic [XLEN-1:0]  id_ex_pc_o,
  output logic [XLEN-1:0]  id_ex_rs1_data_o,
  output logic [XLEN-1:0]  id_ex_rs2_data_o,
  output logic [XLEN-1:0]  id_ex_imm_o,
  output logic [4:0]       id_ex_rs1_o,
  output logic [4:0]       id_ex_rs2_o,
  output logic [4:0]       id_ex_rd_o,
  output logic [2:0]       id_ex_funct3_o,
  output ctrl_t            id_ex_ctrl_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic luh;

  as_load_use_detect u_luh (
    .ex_valid_i    (id_ex_valid_o),
    .ex_mem_rd_i   (id_ex_ctrl_o.mem_rd),
    .ex_rd_i       (id_ex_rd_o),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .luh_o         (luh)
  );

  // Flush and hold both override the stall: the ID instruction is either
  // being discarded or the whole pipeline is frozen anyway.
  assign stall_o = luh & ~flush_i & ~hold_i;

  // NOTE: every register here is state, so it is written with <= only;
  // blocking assignments would make the outcome depend on block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_ex_valid_o    <= 1'b0;
      id_ex_pc_o       <= '0;
      id_ex_rs1_data_o <= '0;
      id_ex_rs2_data_o <= '0;
      id_ex_imm_o      <= '0;
      id_ex_rs1_o      <= '0;
      id_ex_rs2_o      <= '0;
      id_ex_rd_o       <= '0;
      id_ex_funct3_o   <= '0;
      id_ex_ctrl_o     <= CTRL_NOP;
      stall_cnt_o      <= '0;
    end else if (hold_i) begin
      // Frozen: everything keeps its value.
    end else if (flush_i || luh) begin
      // Bubble: rd=0 keeps forwarding from ever matching it.
      id_ex_valid_o    <= 1'b0;
      id_ex_pc_o       <= '0;
      id_ex_rs1_data_o <= '0;
      id_ex_rs2_data_o <= '0;
      id_ex_imm_o      <= '0;
      id_ex_rs1_o      <= '0;
      id_ex_rs2_o      <= '0;
      id_ex_rd_o       <= '0;
      id_ex_funct3_o   <= '0;
      id_ex_ctrl_o     <= CTRL_NOP;
      if (!flush_i && stall_cnt_o != '1) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end else begin
      id_ex_valid_o    <= id_valid_i;
      id_ex_pc_o       <= id_pc_i;
      id_ex_rs1_data_o <= id_rs1_data_i;
      id_ex_rs2_data_o <= id_rs2_data_i;
      id_ex_imm_o      <= id_imm_i;
      id_ex_rs1_o      <= id_rs1_i;
      id_ex_rs2_o      <= id_rs2_i;
      id_ex_rd_o       <= id_valid_i ? id_rd_i : 5'd0;
      id_ex_funct3_o   <= id_funct3_i;
      id_ex_ctrl_o     <= id_valid_i ? id_ctrl_i : CTRL_NOP;
    end
  end

endmodule

// File: tb/tb_as_id_ex_stage.sv
// Self-checking bench for as_id_ex_stage: directed scenarios plus a random
// run, all compared against a transaction-level model of the ID/EX register.
module tb_as_id_ex_stage;
  import as_pack::*;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;
  localparam int VW    = 1 + 4*XLEN + 15 + 3 + $bits(ctrl_t) + CNT_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             hold_i = 1'b0;
  logic             flush_i = 1'b0;
  logic             id_valid_i = 1'b0;
  logic [XLEN-1:0]  id_pc_i = '0, id_rs1_data_i = '0, id_rs2_data_i = '0, id_imm_i = '0;
  logic [4:0]       id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
  logic             id_rs1_used_i = 1'b0, id_rs2_used_i = 1'b0;
  logic [2:0]       id_funct3_i = '0;
  ctrl_t            id_ctrl_i = CTRL_NOP;
  logic             id_ex_valid_o;
  logic [XLEN-1:0]  id_ex_pc_o, id_ex_rs1_data_o, id_ex_rs2_data_o, id_ex_imm_o;
  logic [4:0]       id_ex_rs1_o, id_ex_rs2_o, id_ex_rd_o;
  logic [2:0]       id_ex_funct3_o;
  ctrl_t            id_ex_ctrl_o;
  logic             stall_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int total = 0;
  int bad   = 0;

  as_id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i),
    .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i),
    .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_rs1_used_i(id_rs1_used_i),
    .id_rs2_used_i(id_rs2_used_i), .id_funct3_i(id_funct3_i), .id_ctrl_i(id_ctrl_i),
    .id_ex_valid_o(id_ex_valid_o), .id_ex_pc_o(id_ex_pc_o),
    .id_ex_rs1_data_o(id_ex_rs1_data_o), .id_ex_rs2_data_o(id_ex_rs2_data_o),
    .id_ex_imm_o(id_ex_imm_o), .id_ex_rs1_o(id_ex_rs1_o), .id_ex_rs2_o(id_ex_rs2_o),
    .id_ex_rd_o(id_ex_rd_o), .id_ex_funct3_o(id_ex_funct3_o), .id_ex_ctrl_o(id_ex_ctrl_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: the instruction sitting in EX plus the stall count.
  typedef struct {
    bit              valid;
    logic [XLEN-1:0] pc, rs1d, rs2d, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      f3;
    ctrl_t           ctrl;
  } ex_t;

  ex_t m_ex;
  int  m_cnt;

  function automatic ex_t bubble();
    ex_t b;
    b.valid = 0; b.pc = '0; b.rs1d = '0; b.rs2d = '0; b.imm = '0;
    b.rs1 = '0; b.rs2 = '0; b.rd = '0; b.f3 = '0; b.ctrl = CTRL_NOP;
    return b;
  endfunction

  // A valid instruction must wait when the load ahead of it writes a
  // non-zero register it actually reads.
  function automatic bit m_luh();
    bit reads_it;
    reads_it = (id_rs1_used_i && id_rs1_i == m_ex.rd) || (id_rs2_used_i && id_rs2_i == m_ex.rd);
    return m_ex.valid && m_ex.ctrl.mem_rd && m_ex.rd != 0 && id_valid_i && reads_it;
  endfunction

  function automatic bit m_stall();
    return m_luh() && !flush_i && !hold_i;
  endfunction

  task automatic model_edge();
    bit luh;
    luh = m_luh();
    if (!rst_ni) begin
      m_ex = bubble(); m_cnt = 0;
    end else if (hold_i) begin
    end else if (flush_i) begin
      m_ex = bubble();
    end else if (luh) begin
      m_ex = bubble();
      if (m_cnt < CMAX) m_cnt++;
    end else begin
      m_ex.valid = id_valid_i;
      m_ex.pc = id_pc_i; m_ex.rs1d = id_rs1_data_i; m_ex.rs2d = id_rs2_data_i;
      m_ex.imm = id_imm_i; m_ex.rs1 = id_rs1_i; m_ex.rs2 = id_rs2_i; m_ex.f3 = id_funct3_i;
      m_ex.rd   = id_valid_i ? id_rd_i : 5'd0;
      m_ex.ctrl = id_valid_i ? id_ctrl_i : CTRL_NOP;
    end
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {id_ex_valid_o, id_ex_pc_o, id_ex_rs1_data_o, id_ex_rs2_data_o, id_ex_imm_o,
            id_ex_rs1_o, id_ex_rs2_o, id_ex_rd_o, id_ex_funct3_o, id_ex_ctrl_o, stall_cnt_o};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [CNT_W-1:0] c;
    c = CNT_W'(m_cnt);
    return {m_ex.valid, m_ex.pc, m_ex.rs1d, m_ex.rs2d, m_ex.imm,
            m_ex.rs1, m_ex.rs2, m_ex.rd, m_ex.f3, m_ex.ctrl, c};
  endfunction

  function automatic ctrl_t mk_ctrl(input int kind);
    ctrl_t c;
    c = CTRL_NOP;
    case (kind)
      0: begin c.reg_wr = 1; c.mem_rd = 1; c.mem_to_reg = 1; c.alu_src = 1; end // load
      1: begin c.reg_wr = 1; c.alu_op = 4'd1; end                              // add
      2: begin c.mem_wr = 1; c.alu_src = 1; end                                // store
      default: begin
        logic [$bits(ctrl_t)-1:0] r;
        r = $bits(ctrl_t)'($urandom);
        c = r;
      end
    endcase
    return c;
  endfunction

  task automatic set_id(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input bit u1, input bit u2, input ctrl_t c);
    id_valid_i = v; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
    id_rs1_used_i = u1; id_rs2_used_i = u2; id_ctrl_i = c;
    id_pc_i = {$urandom, $urandom}; id_rs1_data_i = {$urandom, $urandom};
    id_rs2_data_i = {$urandom, $urandom}; id_imm_i = {$urandom, $urandom};
    id_funct3_i = 3'($urandom);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    set_id(1, 5'd1, 5'd2, 5'd3, 1, 1, mk_ctrl(1));
    m_ex = bubble(); m_cnt = 0;
    repeat (2) tick();
    total++;
    if (dut_vec() !== '0 || stall_o !== 1'b0) begin
      bad++; $display("FAIL reset: regs=%h stall=%b want all zero", dut_vec(), stall_o);
    end
    #2 rst_ni = 1;
    tick();
    total++;
    if (dut_vec() !== model_vec()) begin
      bad++; $display("FAIL reset_release: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_load_use();
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 0, mk_ctrl(0)); // ld x5
    tick();
    set_id(1, 5'd5, 5'd7, 5'd6, 1, 1, mk_ctrl(1)); // add x6,x5,x7
    #1; total++;
    if (stall_o !== 1'b1 || m_stall() !== 1'b1) begin
      bad++; $display("FAIL luh_stall: got %b want 1", stall_o);
    end
    tick(); total++;
    if (id_ex_valid_o !== 1'b0 || id_ex_rd_o !== 5'd0 || dut_vec() !== model_vec()) begin
      bad++; $display("FAIL luh_bubble: got %h want %h", dut_vec(), model_vec());
    end
    #1; total++;
    if (stall_o !== 1'b0) begin
      bad++; $display("FAIL luh_single: stall got %b want 0", stall_o);
    end
    tick(); total++;
    if (id_ex_rs1_o !== 5'd5 || stall_cnt_o !== 4'd1 || dut_vec() !== model_vec()) begin
      bad++; $display("FAIL luh_latch: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_store_use();
    set_id(1, 5'd1, 5'd0, 5'd5, 1, 0, mk_ctrl(0));
    tick();
    set_id(1, 5'd2, 5'd5, 5'd0, 0, 1, mk_ctrl(2)); // sw, rs2 = x5
    #1; total++;
    if (stall_o !== 1'b1) begin
      bad++; $display("FAIL sw_rs2_stall: got %b want 1", stall_o);
    end
    tick();
    set_id(1, 5'd1, 5'd0, 5'd5, 1, 0, mk_ctrl(0));
    tick();
    set_id(1, 5'd5, 5'd5, 5'd0, 0, 0, mk_ctrl(2)); // x5 only in unused fields
    #1; total++;
    if (stall_o !== 1'b0) begin
      bad++; $display("FAIL unused_field: got %b want 0", stall_o);
    end
    tick();
    set_id(1, 5'd1, 5'd0, 5'd0, 1, 0, mk_ctrl(0)); // ld x0
    tick();
    set_id(1, 5'd0, 5'd0, 5'd6, 1, 1, mk_ctrl(1));
    #1; total++;
    if (stall_o !== 1'b0) begin
      bad++; $display("FAIL x0_load: got %b want 0", stall_o);
    end
    tick(); total++;
    if (dut_vec() !== model_vec()) begin
      bad++; $display("FAIL x0_follow: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_flush();
    logic [CNT_W-1:0] cnt_before;
    set_id(1, 5'd1, 5'd0, 5'd9, 1, 0, mk_ctrl(0));
    tick();
    cnt_before = stall_cnt_o;
    set_id(1, 5'd9, 5'd3, 5'd4, 1, 1, mk_ctrl(1));
    flush_i = 1;
    #1; total++;
    if (stall_o !== 1'b0) begin
      bad++; $display("FAIL flush_stall: got %b want 0", stall_o);
    end
    tick(); flush_i = 0; total++;
    if (id_ex_valid_o !== 1'b0 || stall_cnt_o !== cnt_before || dut_vec() !== model_vec()) begin
      bad++; $display("FAIL flush_bubble: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_hold();
    logic [VW-1:0] snap;
    set_id(1, 5'd3, 5'd4, 5'd8, 1, 1, mk_ctrl(1));
    tick();
    snap = model_vec();
    hold_i = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5'($urandom), 5'($urandom), 5'($urandom), 1, 1, mk_ctrl(3));
      tick(); total++;
      if (dut_vec() !== snap || dut_vec() !== model_vec()) begin
        bad++; $display("FAIL hold_freeze[%0d]: got %h want %h", i, dut_vec(), snap);
      end
    end
    hold_i = 0;
    set_id(1, 5'd1, 5'd0, 5'd5, 1, 0, mk_ctrl(0));
    tick();
    set_id(1, 5'd5, 5'd0, 5'd6, 1, 0, mk_ctrl(1));
    hold_i = 1;
    #1; total++;
    if (stall_o !== 1'b0) begin
      bad++; $display("FAIL hold_luh: got %b want 0", stall_o);
    end
    tick(); hold_i = 0;
    #1; total++;
    if (stall_o !== 1'b1 || dut_vec() !== model_vec()) begin
      bad++; $display("FAIL hold_release: stall=%b regs %h want %h", stall_o, dut_vec(), model_vec());
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             mk_ctrl($urandom_range(0, 3)));
      hold_i  = ($urandom_range(0, 9) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      #1; total++;
      if (stall_o !== m_stall()) begin
        bad++; $display("FAIL rand_stall[%0d]: got %b want %b", i, stall_o, m_stall());
      end
      tick(); total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL rand_regs[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    hold_i = 0; flush_i = 0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      set_id(1, 5'd1, 5'd0, 5'd5, 1, 0, mk_ctrl(0));
      tick();
      set_id(1, 5'd5, 5'd5, 5'd6, 1, 1, mk_ctrl(1));
      tick(); total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL sat_step[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    total++;
    if (stall_cnt_o !== 4'd15) begin
      bad++; $display("FAIL sat_hold: got %0d want 15", stall_cnt_o);
    end
  endtask

  task automatic test_async_reset();
    set_id(1, 5'd1, 5'd0, 5'd5, 1, 0, mk_ctrl(0));
    tick();
    set_id(1, 5'd5, 5'd0, 5'd6, 1, 0, mk_ctrl(1));
    #1;
    rst_ni = 0;
    m_ex = bubble(); m_cnt = 0;
    #1; total++;
    if (dut_vec() !== '0 || stall_o !== 1'b0) begin
      bad++; $display("FAIL async_reset: regs=%h stall=%b want zero", dut_vec(), stall_o);
    end
    #1 rst_ni = 1;
    tick(); total++;
    if (id_ex_valid_o !== 1'b1 || id_ex_rd_o !== 5'd6 || dut_vec() !== model_vec()) begin
      bad++; $display("FAIL reset_reload: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_store_use();
    test_flush();
    test_hold();
    test_random();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
